adder_display_ctrl: RTL and testbench
=====================================

// Module: adder_display_ctrl
// PURPOSE
//  Sequencing controller for the 3-bit operand adder and the 2-digit 7-segment readout.
//  - On a start request, captures operands a/b and runs them through the ripple adder.
//  - Converts the 4-bit sum (0..14) to tens/ones decimal digits.
//  - Time-multiplexes both digits onto one shared 8-bit segment bus with per-digit enables.
//  - Sits between the operand switches/buttons and the board display pins.
// PARAMETERS
//  REFRESH_DIV    50000  clk cycles each digit is driven before the scanner swaps digits (>=2)
//  BLANK_LEADING  1      1: tens digit blanked when tens==0; 0: tens shows '0'
// PORTS
//  clk      in   1  single system clock; all state changes on the rising edge
//  rst      in   1  synchronous, active-high reset
//  start    in   1  operation request; sampled only in IDLE or SHOW
//  in_a     in   3  operand A, unsigned, captured on an accepted start
//  in_b     in   3  operand B, unsigned, captured on an accepted start
//  busy     out  1  high in ADD and CONV
//  done     out  1  one-cycle pulse on entry to SHOW
//  sum      out  4  registered binary result, valid from the done cycle until the next accepted start
//  seg      out  8  active-low {a,b,c,d,e,f,g,dp}; dp is always 1 (off)
//  dig_sel  out  2  active-low digit enables: [0]=ones, [1]=tens
// BEHAVIOUR
//  Reset values: busy=0, done=0, sum=0, seg=8'hFF, dig_sel=2'b11, state=IDLE, scan counter=0, scan digit=ones.
//  FSM: IDLE -start-> ADD -> CONV -> SHOW -start-> ADD
//   - IDLE: display dark (seg=8'hFF, dig_sel=2'b11); waits for start.
//   - ADD: operands held in a_q/b_q; the adder output is registered into sum at the end of the cycle.
//   - CONV: tens = (sum>=10); ones = tens ? sum-10 : sum; both digits registered.
//   - SHOW: digits displayed; done=1 in the first SHOW cycle only.
//  Latency: start accepted at edge N -> busy high in cycles N+1..N+2 -> done at N+3.
//  start is ignored while busy=1: no queueing, and operands are not re-captured.
//  start in SHOW: new operands captured; the old digits stay displayed until the next CONV completes.
//  start held high continuously: one operation runs per SHOW entry; no extra done pulses.
//  Arithmetic: 3b+3b is zero-extended into 4b. Max 7+7=14, so no overflow is possible. Tens digit is 0 or 1.
//  Scanner (free-running, active only in SHOW):
//   - Counter runs 0..REFRESH_DIV-1; on wrap it returns to 0 and the scan digit toggles.
//   - Ones slot: dig_sel=2'b10, seg=enc(ones).
//   - Tens slot: dig_sel=2'b01, seg=enc(tens), or 8'hFF if BLANK_LEADING && tens==0.
//   - seg and dig_sel are registered and change together; no cycle shows a digit's pattern on the wrong enable.
//  Encoding (active low): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 (hex); any other code=FF.
//  rst mid-operation: the in-flight operation is discarded; all outputs take reset values on the next edge.
//  done is never asserted for an aborted operation.
// STRUCTURE
//  Package adder_disp_pkg holds:
//   - state_t enum {IDLE, ADD, CONV, SHOW};
//   - SEG_BLANK = 8'hFF;
//   - function seg_enc(input [3:0] d) returning the encoding table above.
//  The existing 3-bit ripple adder module `adder` is instantiated unchanged for the ADD step.
//  The scan divider is one natural sub-module: disp_scan_timer (counter + digit toggle, parameter REFRESH_DIV).
// TESTING (bench REFRESH_DIV=4, BLANK_LEADING=1)
//  1. rst for 2 cycles -> seg=FF, dig_sel=11, busy=0, done=0, sum=0; stays so for 20 cycles with start=0.
//  2. a=3, b=4, start pulse -> busy cycles 1-2; done at +3; sum=7; ones slot seg=1F/dig_sel=10; tens slot seg=FF/dig_sel=01.
//  3. a=7, b=7 -> sum=14; tens slot seg=9F; ones slot seg=99. Slots alternate every 4 cycles.
//  4. a=5, b=5 -> sum=10; tens=9F, ones=03. Repeat with BLANK_LEADING=0 and a=0, b=0 -> tens=03, ones=03.
//  5. start re-pulsed while busy=1 with new operands -> ignored; sum is from the first operands; exactly one done.
//  6. rst asserted in CONV -> next edge: seg=FF, dig_sel=11, sum=0; no done; the next start runs normally.

Source files
------------

// File: rtl/adder_disp_pkg.sv
// Shared types and helpers for the adder / 7-segment display controller.
package adder_disp_pkg;

    typedef enum logic [1:0] {IDLE, ADD, CONV, SHOW} state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp}; dp always off.
    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 8'h03;
            4'd1:    seg_enc = 8'h9F;
            4'd2:    seg_enc = 8'h25;
            4'd3:    seg_enc = 8'h0D;
            4'd4:    seg_enc = 8'h99;
            4'd5:    seg_enc = 8'h49;
            4'd6:    seg_enc = 8'h41;
            4'd7:    seg_enc = 8'h1F;
            4'd8:    seg_enc = 8'h01;
            4'd9:    seg_enc = 8'h09;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/adder.sv
// 3-bit ripple-carry adder with the carry out forming the 4th sum bit.
module adder (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [3:0] o_sum
);

    logic w_c1, w_c2, w_c3;

    assign o_sum[0] = i_a[0] ^ i_b[0];
    assign w_c1     = i_a[0] & i_b[0];
    assign o_sum[1] = i_a[1] ^ i_b[1] ^ w_c1;
    assign w_c2     = (i_a[1] & i_b[1]) | (w_c1 & (i_a[1] ^ i_b[1]));
    assign o_sum[2] = i_a[2] ^ i_b[2] ^ w_c2;
    assign w_c3     = (i_a[2] & i_b[2]) | (w_c2 & (i_a[2] ^ i_b[2]));
    assign o_sum[3] = w_c3;

endmodule

// File: rtl/disp_scan_timer.sv
// Digit scan divider: counts 0..REFRESH_DIV-1 while enabled and toggles the scanned digit on wrap.
module disp_scan_timer #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tens_slot_nxt
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_tens_slot, w_tens_slot_d;

    always_comb begin
        w_cnt_d       = r_cnt;
        w_tens_slot_d = r_tens_slot;
        if (i_en) begin
            if (r_cnt == CntW'(REFRESH_DIV - 1)) begin
                w_cnt_d       = '0;
                w_tens_slot_d = ~r_tens_slot;
            end else begin
                w_cnt_d = r_cnt + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_tens_slot <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_d;
            r_tens_slot <= w_tens_slot_d;
        end
    end

    // Next-slot view lets the owner register seg/dig_sel in step with the slot change.
    assign o_tens_slot_nxt = w_tens_slot_d;

endmodule

// File: rtl/adder_display_ctrl.sv
// Sequences operand capture, ripple add, BCD split and multiplexed 2-digit 7-segment output.
module adder_display_ctrl
    import adder_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] sum,
    output logic [7:0] seg,
    output logic [1:0] dig_sel
);

    state_t     r_state, w_state_d;
    logic [2:0] r_a, r_b;
    logic [3:0] r_sum, w_add_sum;
    logic       r_tens, w_tens_d;
    logic [3:0] r_ones, w_ones_d;
    logic       r_valid, w_valid_d;
    logic       r_done;
    logic [7:0] r_seg, w_seg_d;
    logic [1:0] r_dig_sel, w_dig_sel_d;
    logic       w_accept;
    logic       w_tens_slot_d;

    adder u_adder (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_add_sum)
    );

    disp_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk             (clk),
        .rst             (rst),
        .i_en            (r_state == SHOW),
        .o_tens_slot_nxt (w_tens_slot_d)
    );

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        case (r_state)
            IDLE, SHOW: begin
                if (start) begin
                    w_state_d = ADD;
                    w_accept  = 1'b1;
                end
            end
            ADD:     w_state_d = CONV;
            CONV:    w_state_d = SHOW;
            default: w_state_d = IDLE;
        endcase
    end

    // Digits only change when CONV completes, so a restart from SHOW keeps the old readout.
    always_comb begin
        w_tens_d    = r_tens;
        w_ones_d    = r_ones;
        w_valid_d   = r_valid;
        w_seg_d     = SEG_BLANK;
        w_dig_sel_d = 2'b11;
        if (r_state == CONV) begin
            w_tens_d  = (r_sum >= 4'd10);
            w_ones_d  = w_tens_d ? (r_sum - 4'd10) : r_sum;
            w_valid_d = 1'b1;
        end
        if (w_valid_d) begin
            if (w_tens_slot_d) begin
                w_dig_sel_d = 2'b01;
                w_seg_d     = (BLANK_LEADING && !w_tens_d) ? SEG_BLANK
                                                           : seg_enc({3'b000, w_tens_d});
            end else begin
                w_dig_sel_d = 2'b10;
                w_seg_d     = seg_enc(w_ones_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_tens    <= 1'b0;
            r_ones    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_seg     <= SEG_BLANK;
            r_dig_sel <= 2'b11;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            if (r_state == ADD) begin
                r_sum <= w_add_sum;
            end
            r_tens    <= w_tens_d;
            r_ones    <= w_ones_d;
            r_valid   <= w_valid_d;
            r_done    <= (r_state == CONV);
            r_seg     <= w_seg_d;
            r_dig_sel <= w_dig_sel_d;
        end
    end

    assign busy    = (r_state == ADD) || (r_state == CONV);
    assign done    = r_done;
    assign sum     = r_sum;
    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_adder_display_ctrl.sv
// Directed bench: two controllers (leading blank on/off) share stimulus; expectations hand-computed.
module tb_adder_display_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] in_a, in_b;

    logic       busy, done;
    logic [3:0] sum;
    logic [7:0] seg;
    logic [1:0] dig_sel;
    logic       busy0, done0;
    logic [3:0] sum0;
    logic [7:0] seg0;
    logic [1:0] dig_sel0;

    int checks   = 0;
    int failures = 0;
    int n_done;

    always #5 clk = ~clk;

    adder_display_ctrl #(
        .REFRESH_DIV   (4),
        .BLANK_LEADING (1'b1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    adder_display_ctrl #(
        .REFRESH_DIV   (4),
        .BLANK_LEADING (1'b0)
    ) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy0),
        .done    (done0),
        .sum     (sum0),
        .seg     (seg0),
        .dig_sel (dig_sel0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        steps(2);
        rst   = 1'b0;
    endtask

    // Raises start for exactly one sampling edge.
    task automatic pulse_start(input logic [2:0] a, input logic [2:0] b);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;

        // 1. reset state, then idle with start low
        do_reset();
        chk("rst_seg", 16'(seg), 16'hFF);
        chk("rst_dig", 16'(dig_sel), 16'h3);
        chk("rst_busy_done", 16'({busy, done}), 16'h0);
        chk("rst_sum", 16'(sum), 16'h0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_done += int'(done) + int'(busy) + int'(seg != 8'hFF) + int'(dig_sel != 2'b11);
        end
        chk("idle_quiet", 16'(n_done), 16'h0);

        // 2. 3 + 4 = 7
        pulse_start(3'd3, 3'd4);
        chk("t2_busy1", 16'({busy, done}), 16'h2);
        step();
        chk("t2_busy2", 16'({busy, done}), 16'h2);
        step();
        chk("t2_done", 16'({busy, done}), 16'h1);
        chk("t2_sum", 16'(sum), 16'h7);
        chk("t2_ones", 16'({dig_sel, seg}), 16'h21F);
        chk("t2_ones_bl0", 16'({dig_sel0, seg0}), 16'h21F);
        step();
        chk("t2_done_once", 16'(done), 16'h0);
        steps(3);
        chk("t2_tens_blank", 16'({dig_sel, seg}), 16'h1FF);
        chk("t2_tens_bl0", 16'({dig_sel0, seg0}), 16'h103);
        steps(4);
        chk("t2_ones_again", 16'({dig_sel, seg}), 16'h21F);

        // 3. 7 + 7 = 14, started from SHOW: old digit held through ADD/CONV
        pulse_start(3'd7, 3'd7);
        chk("t3_busy1", 16'(busy), 16'h1);
        chk("t3_hold1", 16'({dig_sel, seg}), 16'h21F);
        step();
        chk("t3_hold2", 16'({dig_sel, seg}), 16'h21F);
        step();
        chk("t3_done", 16'(done), 16'h1);
        chk("t3_sum", 16'(sum), 16'hE);
        chk("t3_ones", 16'({dig_sel, seg}), 16'h299);
        steps(3);
        chk("t3_tens", 16'({dig_sel, seg}), 16'h19F);
        steps(3);
        chk("t3_tens_hold", 16'({dig_sel, seg}), 16'h19F);
        step();
        chk("t3_ones_again", 16'({dig_sel, seg}), 16'h299);

        // 4. 5 + 5 = 10, then 0 + 0 with and without leading blank
        do_reset();
        pulse_start(3'd5, 3'd5);
        steps(2);
        chk("t4_sum", 16'(sum), 16'hA);
        chk("t4_ones", 16'({dig_sel, seg}), 16'h203);
        steps(4);
        chk("t4_tens", 16'({dig_sel, seg}), 16'h19F);
        do_reset();
        pulse_start(3'd0, 3'd0);
        steps(2);
        chk("t4z_done", 16'({done, done0}), 16'h3);
        chk("t4z_ones", 16'({dig_sel, seg}), 16'h203);
        chk("t4z_ones_bl0", 16'({dig_sel0, seg0}), 16'h203);
        steps(4);
        chk("t4z_tens_blank", 16'({dig_sel, seg}), 16'h1FF);
        chk("t4z_tens_bl0", 16'({dig_sel0, seg0}), 16'h103);

        // 5. start re-asserted with new operands while busy is ignored
        do_reset();
        in_a  = 3'd2;
        in_b  = 3'd1;
        start = 1'b1;
        step();
        chk("t5_busy1", 16'(busy), 16'h1);
        in_a = 3'd7;
        in_b = 3'd7;
        step();
        chk("t5_busy2", 16'(busy), 16'h1);
        start = 1'b0;
        step();
        chk("t5_done", 16'(done), 16'h1);
        chk("t5_sum", 16'(sum), 16'h3);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_done += int'(done);
        end
        chk("t5_no_extra_done", 16'(n_done), 16'h0);
        chk("t5_sum_hold", 16'(sum), 16'h3);

        // start held high: one operation per SHOW entry
        do_reset();
        in_a   = 3'd1;
        in_b   = 3'd1;
        start  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_done += int'(done);
        end
        start = 1'b0;
        chk("held_done_count", 16'(n_done), 16'h4);
        chk("held_sum", 16'(sum), 16'h2);

        // 6. reset during CONV aborts the operation
        do_reset();
        pulse_start(3'd6, 3'd3);
        step();
        chk("t6_in_conv", 16'(busy), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_abort_out", 16'({dig_sel, seg}), 16'h3FF);
        chk("t6_abort_sum", 16'({busy, done, sum}), 16'h0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_done += int'(done) + int'(busy);
        end
        chk("t6_no_done", 16'(n_done), 16'h0);
        pulse_start(3'd1, 3'd2);
        steps(2);
        chk("t6_rerun_done", 16'(done), 16'h1);
        chk("t6_rerun_sum", 16'(sum), 16'h3);
        chk("t6_rerun_ones", 16'({dig_sel, seg}), 16'h20D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
